// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory adapter.
// Used by lsu_align and lsu_mem_adapter.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_WAIT,
        RMW_RD,
        RMW_WAIT,
        ST_WR,
        RESP
    } state_e;

    localparam logic [2:0]  BYTES_B   = 3'd1;
    localparam logic [2:0]  BYTES_H   = 3'd2;
    localparam logic [2:0]  BYTES_W   = 3'd4;
    localparam logic [31:0] LANE_B    = 32'h0000_00FF;
    localparam logic [31:0] LANE_H    = 32'h0000_FFFF;
    localparam logic [31:0] LANE_W    = 32'hFFFF_FFFF;

    function automatic logic [2:0] size_bytes(input size_e sz);
        case (sz)
            SZ_B:    return BYTES_B;
            SZ_H:    return BYTES_H;
            default: return BYTES_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
// The offset must already be aligned to the access size.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] ld_result,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    assign shamt = {offset, 3'b000};

    always_comb begin
        shifted   = rdata >> shamt;
        ld_result = shifted;
        case (size)
            SZ_B:    ld_result = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
            SZ_H:    ld_result = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            default: ld_result = shifted;
        endcase
    end

    // Old word keeps every byte outside the addressed lanes.
    always_comb begin
        case (size)
            SZ_B:    lane_mask = LANE_B << shamt;
            SZ_H:    lane_mask = LANE_H << shamt;
            default: lane_mask = LANE_W;
        endcase
        merged = (rdata & ~lane_mask) | ((wdata << shamt) & lane_mask);
    end

endmodule

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter between the MEM stage and a word-wide, 1-cycle-latency data memory.
// Define LSU_ERR_CHECK_EN to enable misalignment, size and range error checking.
module lsu_mem_adapter
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic        o_mem_ren,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    if (MEM_BYTES < 4 || (MEM_BYTES % 4) != 0) begin : g_mem_bytes_check
        $error("lsu_mem_adapter: MEM_BYTES must be a positive multiple of 4");
    end

    state_e      state;
    logic [29:0] word_addr_q;
    logic [31:0] wdata_q;
    size_e       size_q;
    logic [1:0]  off_q;
    logic        unsigned_q;

    size_e       req_size;
    logic [1:0]  req_off;
    logic        req_err;
    logic [31:0] ld_result;
    logic [31:0] merged;

    // Size 11 behaves as a word and offsets snap to the access size, so the
    // lane logic never sees an unaligned half or word.
    always_comb begin
        req_size = size_e'(i_req_size);
        if (req_size == SZ_X) begin
            req_size = SZ_W;
        end
        case (req_size)
            SZ_B:    req_off = i_req_addr[1:0];
            SZ_H:    req_off = {i_req_addr[1], 1'b0};
            default: req_off = 2'b00;
        endcase
    end

`ifdef LSU_ERR_CHECK_EN
    logic [32:0] req_end;

    always_comb begin
        req_end = {1'b0, i_req_addr} + 33'(size_bytes(req_size));
        req_err = (i_req_size == 2'b11)
               || (i_req_size == 2'b01 && i_req_addr[0])
               || (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00)
               || (req_end > 33'(MEM_BYTES));
    end
`else
    assign req_err = 1'b0;
`endif

    lsu_align u_align (
        .rdata       (i_mem_rdata),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .wdata       (wdata_q),
        .ld_result   (ld_result),
        .merged      (merged)
    );

    assign o_req_ready = (state == IDLE);
    assign o_mem_addr  = {word_addr_q, 2'b00};
    // Gated by reset so an access interrupted by reset never reaches memory.
    assign o_mem_ren   = i_rst_n && (state == LD_RD || state == RMW_RD);
    assign o_mem_wren  = i_rst_n && (state == ST_WR);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_resp_valid <= 1'b0;
            o_resp_rdata <= '0;
            o_resp_err   <= 1'b0;
            o_mem_wdata  <= '0;
            word_addr_q  <= '0;
            wdata_q      <= '0;
            size_q       <= SZ_B;
            off_q        <= 2'b00;
            unsigned_q   <= 1'b0;
        end else begin
            o_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        word_addr_q <= i_req_addr[31:2];
                        wdata_q     <= i_req_wdata;
                        size_q      <= req_size;
                        off_q       <= req_off;
                        unsigned_q  <= i_req_unsigned;
                        if (req_err) begin
                            state        <= RESP;
                            o_resp_valid <= 1'b1;
                            o_resp_rdata <= '0;
                            o_resp_err   <= 1'b1;
                        end else if (!i_req_we) begin
                            state <= LD_RD;
                        end else if (req_size == SZ_W) begin
                            state       <= ST_WR;
                            o_mem_wdata <= i_req_wdata;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LD_RD:    state <= LD_WAIT;
                LD_WAIT: begin
                    state        <= RESP;
                    o_resp_valid <= 1'b1;
                    o_resp_rdata <= ld_result;
                    o_resp_err   <= 1'b0;
                end
                RMW_RD:   state <= RMW_WAIT;
                RMW_WAIT: begin
                    state       <= ST_WR;
                    o_mem_wdata <= merged;
                end
                ST_WR: begin
                    state        <= RESP;
                    o_resp_valid <= 1'b1;
                    o_resp_rdata <= '0;
                    o_resp_err   <= 1'b0;
                end
                RESP:     state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Directed bench for lsu_mem_adapter with a word-wide 1-cycle-latency memory model.
// Error-path expectations follow LSU_ERR_CHECK_EN.
module tb_lsu_mem_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_resp_valid;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;
    logic        o_mem_ren;
    logic        o_mem_wren;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata = 32'h0;

    logic [31:0] mem [0:127];

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          ren;
        int          wren;
        logic [31:0] wd;
        logic [31:0] wa;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    lsu_mem_adapter #(.MEM_BYTES(512)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .o_resp_valid   (o_resp_valid),
        .o_resp_rdata   (o_resp_rdata),
        .o_resp_err     (o_resp_err),
        .o_mem_ren      (o_mem_ren),
        .o_mem_wren     (o_mem_wren),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_rdata    (i_mem_rdata)
    );

    always @(posedge clk) begin
        if (o_mem_ren) i_mem_rdata <= mem[o_mem_addr[8:2]];
        if (o_mem_wren) mem[o_mem_addr[8:2]] <= o_mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                           input int e_ren, input int e_wren, input logic [31:0] e_wd);
        exp_t e;
        exp_t p;
        int cyc;
        int rc;
        int wc;
        int both;
        logic [31:0] got_wd;
        logic [31:0] got_wa;
        @(negedge clk);
        chk({tag, "_ready"}, 32'(o_req_ready), 32'd1);
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_size     = sz;
        i_req_unsigned = uns;
        i_req_addr     = addr;
        i_req_wdata    = wd;
        e.tag = tag; e.rdata = e_rdata; e.err = e_err; e.lat = e_lat;
        e.ren = e_ren; e.wren = e_wren; e.wd = e_wd; e.wa = {addr[31:2], 2'b00};
        sb.push_back(e);
        cyc = 0; rc = 0; wc = 0; both = 0; got_wd = '0; got_wa = '0;
        do begin
            @(negedge clk);
            cyc++;
            i_req_valid = 1'b0;
            if (o_mem_ren) rc++;
            if (o_mem_wren) begin
                wc++;
                got_wd = o_mem_wdata;
                got_wa = o_mem_addr;
            end
            if (o_mem_ren && o_mem_wren) both++;
        end while (!o_resp_valid && cyc < 12);
        p = sb.pop_front();
        chk({p.tag, "_valid"}, 32'(o_resp_valid), 32'd1);
        chk({p.tag, "_latency"}, 32'(cyc), 32'(p.lat));
        chk({p.tag, "_rdata"}, o_resp_rdata, p.rdata);
        chk({p.tag, "_err"}, 32'(o_resp_err), 32'(p.err));
        chk({p.tag, "_ren_count"}, 32'(rc), 32'(p.ren));
        chk({p.tag, "_wren_count"}, 32'(wc), 32'(p.wren));
        chk({p.tag, "_ren_wren_overlap"}, 32'(both), 32'd0);
        if (p.wren > 0) begin
            chk({p.tag, "_wdata"}, got_wd, p.wd);
            chk({p.tag, "_waddr"}, got_wa, p.wa);
        end
        @(negedge clk);
        chk({p.tag, "_pulse_end"}, 32'(o_resp_valid), 32'd0);
    endtask

    initial begin
        int bad;
        rst_n          = 1'b0;
        i_req_valid    = 1'b0;
        i_req_we       = 1'b0;
        i_req_size     = 2'b00;
        i_req_unsigned = 1'b0;
        i_req_addr     = '0;
        i_req_wdata    = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
        chk("rst_resp_rdata", o_resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(o_resp_err), 32'd0);
        chk("rst_mem_wdata", o_mem_wdata, 32'h0);
        chk("rst_ren", 32'(o_mem_ren), 32'd0);
        chk("rst_wren", 32'(o_mem_wren), 32'd0);
        rst_n = 1'b1;

        // Preload through the DUT, then loads of every width
        run_req("sw_pre",   1'b1, 2'b10, 1'b0, 32'h10, 32'h8070F1A2, 32'h0, 1'b0, 2, 0, 1, 32'h8070F1A2);
        run_req("lb_11",    1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFF1, 1'b0, 3, 1, 0, 32'h0);
        run_req("lhu_12",   1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00008070, 1'b0, 3, 1, 0, 32'h0);
        run_req("lh_12",    1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8070, 1'b0, 3, 1, 0, 32'h0);
        run_req("lbu_13",   1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 3, 1, 0, 32'h0);
        run_req("lb_10",    1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFA2, 1'b0, 3, 1, 0, 32'h0);

        // Sub-word store via read-modify-write
        run_req("sb_13",    1'b1, 2'b00, 1'b0, 32'h13, 32'h00000055, 32'h0, 1'b0, 4, 1, 1, 32'h5570F1A2);
        run_req("lw_10",    1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h5570F1A2, 1'b0, 3, 1, 0, 32'h0);

`ifdef LSU_ERR_CHECK_EN
        run_req("err_lw_12",  1'b0, 2'b10, 1'b0, 32'h12,  32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        run_req("err_sh_11",  1'b1, 2'b01, 1'b0, 32'h11,  32'h1234, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        run_req("err_lw_1fe", 1'b0, 2'b10, 1'b0, 32'h1FE, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        run_req("err_sz11",   1'b0, 2'b11, 1'b0, 32'h10,  32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        run_req("ok_lw_1fc",  1'b1, 2'b10, 1'b0, 32'h1FC, 32'h600DF00D, 32'h0, 1'b0, 2, 0, 1, 32'h600DF00D);
`else
        run_req("lw_12_noerr", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h5570F1A2, 1'b0, 3, 1, 0, 32'h0);
        run_req("sz11_as_w",   1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h5570F1A2, 1'b0, 3, 1, 0, 32'h0);
        run_req("lh_13_noerr", 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h00005570, 1'b0, 3, 1, 0, 32'h0);
`endif

        // Word store
        run_req("sw_20",    1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 32'hDEADBEEF);

        // Request held valid while busy: second one accepted only after RESP
        @(negedge clk);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'b10;
        i_req_unsigned = 1'b0; i_req_addr = 32'h24; i_req_wdata = 32'h0BADF00D;
        @(negedge clk);
        chk("held_c1_wren", 32'(o_mem_wren), 32'd1);
        chk("held_c1_ready", 32'(o_req_ready), 32'd0);
        i_req_we = 1'b0;
        @(negedge clk);
        chk("held_c2_resp", 32'(o_resp_valid), 32'd1);
        chk("held_c2_ready", 32'(o_req_ready), 32'd0);
        chk("held_c2_wren", 32'(o_mem_wren), 32'd0);
        @(negedge clk);
        chk("held_c3_ready", 32'(o_req_ready), 32'd1);
        chk("held_c3_ren", 32'(o_mem_ren), 32'd0);
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("held_ld_ren", 32'(o_mem_ren), 32'd1);
        repeat (2) @(negedge clk);
        chk("held_ld_resp", 32'(o_resp_valid), 32'd1);
        chk("held_ld_rdata", o_resp_rdata, 32'h0BADF00D);

        // Reset during RMW_WAIT: dropped, no write
        @(negedge clk);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'b01;
        i_req_addr = 32'h10; i_req_wdata = 32'h00001234;
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("rstw_ren", 32'(o_mem_ren), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstw_rdata", o_resp_rdata, 32'h0);
        chk("rstw_err", 32'(o_resp_err), 32'd0);
        chk("rstw_wdata", o_mem_wdata, 32'h0);
        chk("rstw_ready", 32'(o_req_ready), 32'd1);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (o_mem_wren || o_resp_valid) bad++;
        end
        chk("rstw_no_activity", 32'(bad), 32'd0);
        chk("rstw_mem", mem[4], 32'h5570F1A2);

        // Reset during ST_WR: write enable must be gated off
        @(negedge clk);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'b00;
        i_req_addr = 32'h10; i_req_wdata = 32'h00000099;
        @(negedge clk);
        i_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rsts_wren_gated", 32'(o_mem_wren), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rsts_resp", 32'(o_resp_valid), 32'd0);
        chk("rsts_mem", mem[4], 32'h5570F1A2);

        run_req("post_rst_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h5570F1A2, 1'b0, 3, 1, 0, 32'h0);
        run_req("post_rst_sh", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000ABCD, 32'h0, 1'b0, 4, 1, 1, 32'hABCDF1A2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
